// File: rtl/demux_dut.sv
// 1-to-4 demultiplexer with a 2-entry FIFO per output channel.
// Optional sticky drop flag `err` is built only when DEMUX_ERR_EN is defined.
module demux_dut #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic             s0,
    input  logic             s1,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [3:0]       y_valid,
    input  logic [3:0]       y_ready
`ifdef DEMUX_ERR_EN
    ,
    output logic             err
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_q  [4];
    state_t           state_d  [4];
    logic [WIDTH-1:0] mem_q    [4][DEPTH];
    logic [WIDTH-1:0] mem_d    [4][DEPTH];
    logic             wr_ptr_q [4];
    logic             wr_ptr_d [4];
    logic             rd_ptr_q [4];
    logic             rd_ptr_d [4];
    logic [1:0]       sel_s;
    logic             in_ready_s;
    logic [3:0]       push_s;
    logic [3:0]       pop_s;

    // Handshake decode and per-channel next-state / buffer update
    always_comb begin
        sel_s      = {s1, s0};
        // A full channel can still accept when its head leaves this same cycle.
        in_ready_s = (state_q[sel_s] != ST_FULL) || y_ready[sel_s];
        push_s     = 4'b0000;
        pop_s      = 4'b0000;
        mem_d      = mem_q;
        for (int n = 0; n < 4; n++) begin
            push_s[n]   = in_valid && in_ready_s && (sel_s == 2'(n));
            pop_s[n]    = (state_q[n] != ST_EMPTY) && y_ready[n];
            state_d[n]  = state_q[n];
            wr_ptr_d[n] = wr_ptr_q[n];
            rd_ptr_d[n] = rd_ptr_q[n];
            if (push_s[n]) begin
                mem_d[n][wr_ptr_q[n]] = d;
                wr_ptr_d[n]           = ~wr_ptr_q[n];
            end else begin
                wr_ptr_d[n] = wr_ptr_q[n];
            end
            if (pop_s[n]) begin
                rd_ptr_d[n] = ~rd_ptr_q[n];
            end else begin
                rd_ptr_d[n] = rd_ptr_q[n];
            end
            case (state_q[n])
                ST_EMPTY: begin
                    if (push_s[n]) state_d[n] = ST_ONE;
                    else           state_d[n] = ST_EMPTY;
                end
                ST_ONE: begin
                    if (push_s[n] && !pop_s[n])      state_d[n] = ST_FULL;
                    else if (pop_s[n] && !push_s[n]) state_d[n] = ST_EMPTY;
                    else                             state_d[n] = ST_ONE;
                end
                ST_FULL: begin
                    if (pop_s[n] && !push_s[n]) state_d[n] = ST_ONE;
                    else                        state_d[n] = ST_FULL;
                end
                default: state_d[n] = ST_EMPTY;
            endcase
        end
    end

    // Channel state, pointers and storage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 4; n++) begin
                state_q[n]  <= ST_EMPTY;
                wr_ptr_q[n] <= 1'b0;
                rd_ptr_q[n] <= 1'b0;
                for (int e = 0; e < DEPTH; e++) begin
                    mem_q[n][e] <= {WIDTH{1'b0}};
                end
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                state_q[n]  <= state_d[n];
                wr_ptr_q[n] <= wr_ptr_d[n];
                rd_ptr_q[n] <= rd_ptr_d[n];
                for (int e = 0; e < DEPTH; e++) begin
                    mem_q[n][e] <= mem_d[n][e];
                end
            end
        end
    end

`ifdef DEMUX_ERR_EN
    logic err_q;

    // Sticky flag for any word offered while the selected channel refused it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | (in_valid & ~in_ready_s);
        end
    end

    assign err = err_q;
`endif

    assign in_ready = in_ready_s;
    assign y0       = mem_q[0][rd_ptr_q[0]];
    assign y1       = mem_q[1][rd_ptr_q[1]];
    assign y2       = mem_q[2][rd_ptr_q[2]];
    assign y3       = mem_q[3][rd_ptr_q[3]];

    // Head data comes straight from storage; validity decodes the state register
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            y_valid[n] = (state_q[n] != ST_EMPTY);
        end
    end

endmodule

// File: tb/tb_demux_dut.sv
// Scoreboard bench for demux_dut: per-channel expected queues filled on push, checked on output.
module tb_demux_dut;

    logic       clk;
    logic       rst_n;
    logic [7:0] d;
    logic       s0;
    logic       s1;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] y0;
    logic [7:0] y1;
    logic [7:0] y2;
    logic [7:0] y3;
    logic [3:0] y_valid;
    logic [3:0] y_ready;
`ifdef DEMUX_ERR_EN
    logic       err;
`endif

    int         checks;
    int         errors;
    logic [7:0] sbq [4][$];
    logic       err_exp;

    demux_dut #(.WIDTH(8), .DEPTH(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d        (d),
        .s0       (s0),
        .s1       (s1),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y0       (y0),
        .y1       (y1),
        .y2       (y2),
        .y3       (y3),
        .y_valid  (y_valid),
        .y_ready  (y_ready)
`ifdef DEMUX_ERR_EN
        ,
        .err      (err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] y_of(input int n);
        case (n)
            0:       return y0;
            1:       return y1;
            2:       return y2;
            default: return y3;
        endcase
    endfunction

    // One clock cycle: drive at negedge, check outputs against the model, update the model.
    task automatic step(input logic [7:0] dv, input logic [1:0] sel, input logic iv, input logic [3:0] yr);
        logic exp_rdy;
        @(negedge clk);
        d        = dv;
        {s1, s0} = sel;
        in_valid = iv;
        y_ready  = yr;
        #1;
        exp_rdy = (sbq[sel].size() < 2) || yr[sel];
        check_eq("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        for (int n = 0; n < 4; n++) begin
            check_eq($sformatf("y_valid[%0d]", n), {31'd0, y_valid[n]}, {31'd0, (sbq[n].size() > 0)});
            if (sbq[n].size() > 0) begin
                check_eq($sformatf("y%0d", n), {24'd0, y_of(n)}, {24'd0, sbq[n][0]});
            end
        end
`ifdef DEMUX_ERR_EN
        check_eq("err", {31'd0, err}, {31'd0, err_exp});
        if (iv && !exp_rdy) err_exp = 1'b1;
`endif
        for (int n = 0; n < 4; n++) begin
            if (sbq[n].size() > 0 && yr[n]) void'(sbq[n].pop_front());
        end
        if (iv && exp_rdy) sbq[sel].push_back(dv);
    endtask

    task automatic clear_model();
        for (int n = 0; n < 4; n++) sbq[n].delete();
        err_exp = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        err_exp  = 1'b0;
        rst_n    = 1'b0;
        d        = 8'h00;
        {s1, s0} = 2'd0;
        in_valid = 1'b0;
        y_ready  = 4'b0000;

        // Reset state
        #2;
        check_eq("rst_y_valid", {28'd0, y_valid}, 32'd0);
        check_eq("rst_y0", {24'd0, y0}, 32'd0);
        check_eq("rst_y3", {24'd0, y3}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single word to channel 2, then drain
        step(8'hA5, 2'd2, 1'b1, 4'b0000);
        step(8'h00, 2'd0, 1'b0, 4'b0000);
        check_eq("ch2_y_valid_vec", {28'd0, y_valid}, 32'h4);
        step(8'h00, 2'd0, 1'b0, 4'b0100);
        step(8'h00, 2'd0, 1'b0, 4'b0000);

        // Fill channel 1, attempt a third word (dropped), drain in order
        step(8'h11, 2'd1, 1'b1, 4'b0000);
        step(8'h22, 2'd1, 1'b1, 4'b0000);
        step(8'h33, 2'd1, 1'b1, 4'b0000);
        step(8'h00, 2'd1, 1'b0, 4'b0010);
        step(8'h00, 2'd1, 1'b0, 4'b0010);
        step(8'h00, 2'd1, 1'b0, 4'b0000);

        // Channel 3 full, push and pop together, then drain
        step(8'h01, 2'd3, 1'b1, 4'b0000);
        step(8'h02, 2'd3, 1'b1, 4'b0000);
        step(8'h03, 2'd3, 1'b1, 4'b1000);
        step(8'h00, 2'd3, 1'b0, 4'b1000);
        step(8'h00, 2'd3, 1'b0, 4'b1000);
        step(8'h00, 2'd3, 1'b0, 4'b0000);

        // Push and pop together on a channel holding one word
        step(8'h44, 2'd0, 1'b1, 4'b0000);
        step(8'h55, 2'd0, 1'b1, 4'b0001);
        step(8'h00, 2'd0, 1'b0, 4'b0001);
        step(8'h00, 2'd0, 1'b0, 4'b0000);

        // Round-robin select at full throughput
        for (int i = 0; i < 16; i++) step(8'(i), 2'(i % 4), 1'b1, 4'b1111);
        for (int i = 0; i < 3; i++) step(8'h00, 2'd0, 1'b0, 4'b1111);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom));
        end
        for (int i = 0; i < 3; i++) step(8'h00, 2'd0, 1'b0, 4'b1111);

        // Reset between edges discards channel 0 contents
        step(8'h66, 2'd0, 1'b1, 4'b0000);
        step(8'h77, 2'd0, 1'b1, 4'b0000);
        step(8'h88, 2'd0, 1'b1, 4'b0000);
        @(negedge clk);
        in_valid = 1'b0;
        y_ready  = 4'b0000;
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_y_valid", {28'd0, y_valid}, 32'd0);
        check_eq("midrst_y0", {24'd0, y0}, 32'd0);
        clear_model();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step(8'h99, 2'd0, 1'b1, 4'b0000);
        step(8'h00, 2'd0, 1'b0, 4'b0001);
        step(8'h00, 2'd0, 1'b0, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_dut.md
DEMUX_DUT -- requirements
Module: demux_dut

Interface
REQ-001 Parameter WIDTH, default 8, data width of the input and of each output channel.
REQ-002 Parameter DEPTH, fixed at 2, entries per output channel buffer; no other value is supported.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 d  input  WIDTH  input data word.
REQ-006 s0  input  1  channel select LSB.
REQ-007 s1  input  1  channel select MSB; channel index = {s1,s0}.
REQ-008 in_valid  input  1  input word present.
REQ-009 in_ready  output  1  selected channel can accept a word this cycle.
REQ-010 y0, y1, y2, y3  output  WIDTH each  head-of-buffer data per channel.
REQ-011 y_valid  output  4  bit n set: channel n holds a word.
REQ-012 y_ready  input  4  bit n set: consumer takes channel n head this cycle.
REQ-013 err  output  1  sticky drop flag; present only with DEMUX_ERR_EN.

Function
REQ-014 Input transfer occurs on a rising clk edge when in_valid and in_ready are both 1; d is written to channel {s1,s0}.
REQ-015 in_ready is combinational: 1 when channel {s1,s0} is not FULL, or when it is FULL and its y_ready bit is 1 in the same cycle.
REQ-016 Each channel runs a three-state FSM: EMPTY (0 words), ONE (1 word), FULL (2 words).
REQ-017 Transitions: push only raises the count by one, pop only lowers it by one, push and pop together hold the count, and neither holds the count.
REQ-018 Output transfer on channel n occurs when y_valid[n] and y_ready[n] are both 1; y_ready[n] while y_valid[n] is 0 is ignored.
REQ-019 Buffers are FIFO order; yN shows the oldest word and is stable while y_valid[n]=1 and y_ready[n]=0.
REQ-020 Latency: a word accepted at edge k appears on yN with y_valid[n]=1 after edge k (one cycle) when channel n was EMPTY.
REQ-021 Simultaneous push and pop on a FULL channel is accepted; the count stays at FULL with no loss.
REQ-022 Simultaneous push and pop on an ONE channel: the head advances to the pushed word and the count stays at ONE.
REQ-023 Non-selected channels continue draining independently in every cycle.
REQ-024 Pointers are 1 bit per channel and wrap modulo 2.
REQ-025 yN content when y_valid[n]=0 is don't-care and must not be checked.

Reset
REQ-026 rst_n low forces every channel to EMPTY, all pointers to 0, y_valid=4'b0000, y0..y3=0, and err=0, immediately and independently of clk.
REQ-027 Reset asserted mid-transfer discards all buffered words; no transfer completes on an edge where rst_n is low.
REQ-028 The first transfer after reset release can occur on the first rising edge with rst_n high.

Configuration
REQ-029 Macro DEMUX_ERR_EN defined: err is set on any edge with in_valid=1 and in_ready=0, and stays 1 until reset.
REQ-030 Macro DEMUX_ERR_EN undefined: the err port and its logic are absent and the block is otherwise identical.

Verification
REQ-031 Reset then d=8'hA5, {s1,s0}=2, in_valid=1 for 1 cycle, y_ready=0 -> y_valid=4'b0100 and y2=8'hA5 one cycle later; other bits stay 0.
REQ-032 Push 8'h11 then 8'h22 to channel 1 with y_ready=0 -> channel 1 is FULL and in_ready=0 for select 1; then y_ready[1]=1 for 2 cycles -> y1 shows 8'h11 then 8'h22, then y_valid[1]=0.
REQ-033 Channel 3 FULL with 8'h01 and 8'h02, push 8'h03 with y_ready[3]=1 -> in_ready=1 and the output order is 01, 02, 03 with no loss.
REQ-034 Alternate select 0,1,2,3 every cycle with data 0..15 and all y_ready=1 -> each channel outputs its four words in order, with throughput one word per cycle.
REQ-035 Fill channel 0, drop rst_n low between edges -> y_valid=0 immediately, and channel 0 accepts a new word on the first edge after release.
REQ-036 With DEMUX_ERR_EN defined: push to a FULL channel with its y_ready bit 0 -> err=1 next cycle and held until rst_n low; without the macro, the same stimulus leaves channel contents unchanged.
